// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, lock wait, stability qualification and run,
// retrying a failed lock and latching FAULT after repeated failures.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

    localparam int MAX_AB     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYCLES = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t        state_q, state_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic [3:0]    retry_q, retry_nx;
    logic [7:0]    loss_nx;
    logic          lock_m, lock_s;
    logic          pll_reset_nx, sys_rst_nx, ready_nx, fault_nx;

    assign state = state_q;

    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_cnt  <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            lock_m    <= pll_lock;
            lock_s    <= lock_m;
            state_q   <= state_nx;
            cnt_q     <= cnt_nx;
            retry_q   <= retry_nx;
            loss_cnt  <= loss_nx;
            pll_reset <= pll_reset_nx;
            sys_rst   <= sys_rst_nx;
            ready     <= ready_nx;
            fault     <= fault_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q + CW'(1);
        retry_nx = retry_q;
        loss_nx  = loss_cnt;

        if (restart) begin
            state_nx = RESET_PLL;
            cnt_nx   = '0;
            retry_nx = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_nx = WAIT_LOCK;
                        cnt_nx   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = STABLE;
                        cnt_nx   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_nx = retry_q + 4'd1;
                        cnt_nx   = '0;
                        state_nx = (retry_nx == RETRY_LIMIT) ? FAULT : RESET_PLL;
                    end
                end
                STABLE: begin
                    // A lock drop wins over reaching the stability count on the same cycle
                    if (!lock_s) begin
                        state_nx = WAIT_LOCK;
                        cnt_nx   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                        retry_nx = '0;
                    end
                end
                RUN: begin
                    cnt_nx = '0;
                    if (!lock_s) begin
                        state_nx = RESET_PLL;
                        if (loss_cnt != '1) loss_nx = loss_cnt + 8'd1;
                    end
                end
                FAULT: begin
                    cnt_nx = '0;
                end
                default: begin
                    state_nx = RESET_PLL;
                    cnt_nx   = '0;
                end
            endcase
        end

        pll_reset_nx = 1'b1;
        sys_rst_nx   = 1'b1;
        ready_nx     = 1'b0;
        fault_nx     = 1'b0;
        case (state_nx)
            WAIT_LOCK, STABLE: pll_reset_nx = 1'b0;
            RUN: begin
                pll_reset_nx = 1'b0;
                sys_rst_nx   = 1'b0;
                ready_nx     = 1'b1;
            end
            FAULT: fault_nx = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomised scoreboard bench for pll_lock_supervisor against a cycle-level behavioural model.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 8;
    localparam int STABLE_CYCLES = 4;
    localparam int MAX_RETRY     = 2;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_rst, ready, fault;
    logic [2:0] state;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .restart  (restart),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .fault    (fault),
        .state    (state),
        .loss_cnt (loss_cnt)
    );

    typedef struct {
        int st;
        bit pr, sr, rd, ft;
        int loss;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    // Reference model: phase number, cycles already spent in the phase, retries, losses,
    // and the last two sampled lock values (the synchroniser delay).
    int m_state = 0, m_age = 0, m_retry = 0, m_loss = 0;
    bit m_s1 = 0, m_s2 = 0;

    task automatic model_step(input bit rst, input bit rs, input bit lk);
        int nxt;
        int nage;
        exp_t e;
        if (rst) begin
            m_state = 0; m_age = 0; m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            nxt  = m_state;
            nage = m_age + 1;
            if (rs) begin
                nxt = 0; nage = 0; m_retry = 0;
            end else if (m_state == 0) begin
                if (nage >= RST_CYCLES) begin nxt = 1; nage = 0; end
            end else if (m_state == 1) begin
                if (m_s2) begin
                    nxt = 2; nage = 0;
                end else if (nage >= LOCK_TIMEOUT) begin
                    m_retry = m_retry + 1;
                    nxt = (m_retry == MAX_RETRY) ? 4 : 0;
                    nage = 0;
                end
            end else if (m_state == 2) begin
                if (!m_s2) begin
                    nxt = 1; nage = 0;
                end else if (nage >= STABLE_CYCLES) begin
                    nxt = 3; nage = 0; m_retry = 0;
                end
            end else if (m_state == 3) begin
                if (!m_s2) begin
                    nxt = 0; nage = 0;
                    m_loss = (m_loss >= 255) ? 255 : m_loss + 1;
                end
            end
            m_state = nxt;
            m_age   = nage;
            m_s2    = m_s1;
            m_s1    = lk;
        end
        e.st   = m_state;
        e.pr   = (m_state == 0) || (m_state == 4);
        e.sr   = (m_state != 3);
        e.rd   = (m_state == 3);
        e.ft   = (m_state == 4);
        e.loss = m_loss;
        sb.push_back(e);
    endtask

    always @(negedge clkin) begin
        if (sb.size() != 0) begin
            me = sb.pop_front();
            checks++;
            if (state !== 3'(me.st) || pll_reset !== me.pr || sys_rst !== me.sr ||
                ready !== me.rd || fault !== me.ft || loss_cnt !== 8'(me.loss)) begin
                errors++;
                $display("FAIL outputs t=%0t got st=%0d pr=%b sr=%b rd=%b ft=%b loss=%0d, exp st=%0d pr=%b sr=%b rd=%b ft=%b loss=%0d",
                         $time, state, pll_reset, sys_rst, ready, fault, loss_cnt,
                         me.st, me.pr, me.sr, me.rd, me.ft, me.loss);
            end
        end
    end

    task automatic wait_slot();
        @(negedge clkin);
        #1;
    endtask

    task automatic drive(input bit rst, input bit rs, input bit lk, input bit glitch);
        int d;
        reset   = rst;
        restart = rs;
        pll_lock = glitch ? ~lk : lk;
        model_step(rst, rs, lk);
        if (glitch) begin
            d = $urandom_range(3, 1);
            #(d);
            pll_lock = lk;
        end
    endtask

    task automatic step(input bit rst, input bit rs, input bit lk, input bit glitch);
        wait_slot();
        drive(rst, rs, lk, glitch);
    endtask

    task automatic run_until(input int target, input bit lk, input int maxc);
        int n;
        n = 0;
        wait_slot();
        while (state !== 3'(target) && n < maxc) begin
            drive(1'b0, 1'b0, lk, 1'b0);
            wait_slot();
            n++;
        end
        checks++;
        if (state !== 3'(target)) begin
            errors++;
            $display("FAIL wait_state got=%0d want=%0d after %0d cycles", state, target, n);
        end
        drive(1'b0, 1'b0, lk, 1'b0);
    endtask

    task automatic dcheck(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    bit r_rst, r_rs, r_lk, r_gl;

    initial begin
        // Lock tied high from reset: reset pulse, wait, qualify, run
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        wait_slot();
        dcheck("run_ready", 32'(ready), 32'd1);
        dcheck("run_loss0", 32'(loss_cnt), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Lock never arrives: two timed-out windows then FAULT, cleared by restart
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_until(4, 1'b0, 60);
        wait_slot();
        dcheck("fault_state", 32'(state), 32'd4);
        dcheck("fault_flag", 32'(fault), 32'd1);
        dcheck("fault_pll_reset", 32'(pll_reset), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        wait_slot();
        dcheck("restart_state", 32'(state), 32'd0);
        dcheck("restart_fault", 32'(fault), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // One-cycle lock drop during STABLE
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run_until(2, 1'b1, 30);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        run_until(3, 1'b1, 40);

        // Three lock losses in RUN with relock
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            run_until(0, 1'b1, 10);
            run_until(3, 1'b1, 40);
        end
        wait_slot();
        dcheck("loss_three", 32'(loss_cnt), 32'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Restart coinciding with the synchronised lock drop
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        wait_slot();
        dcheck("restart_drop_state", 32'(state), 32'd0);
        dcheck("restart_drop_loss", 32'(loss_cnt), 32'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Saturating loss counter
        for (int i = 0; i < 300; i++) begin
            run_until(3, 1'b1, 40);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            run_until(0, 1'b1, 10);
        end
        wait_slot();
        dcheck("loss_saturate", 32'(loss_cnt), 32'd255);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset dominates restart and clears the loss count
        step(1'b1, 1'b1, 1'b1, 1'b0);
        wait_slot();
        dcheck("reset_restart_loss", 32'(loss_cnt), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Random lock pattern with sub-cycle glitches, occasional restart and reset
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom_range(199, 0) == 0);
            r_rs  = ($urandom_range(99, 0) == 0);
            r_lk  = ($urandom_range(99, 0) < 88);
            r_gl  = ($urandom_range(3, 0) == 0);
            step(r_rst, r_rs, r_lk, r_gl);
        end

        wait_slot();
        dcheck("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
